result_stream_serializer: RTL and testbench
===========================================

# result_stream_serializer

Downstream stage of the systolic-array AXI wrapper. It takes the wrapper's 144-bit result beats, nine 16-bit results of a 3×3 tile, and serializes each into three 48-bit AXI-Stream beats for the S2MM DMA channel. It counts result words per frame and drives `m_axis_last` so the DMA can close each transfer. Single-entry buffering with pass-through ready sustains one input word every N cycles with no bubble.

## Interface
Parameters:
- `IN_W`, 144, input beat width; must be an integer multiple of `OUT_W`.
- `OUT_W`, 48, output beat width.
- `N` (localparam), `IN_W/OUT_W` = 3, slices per input word.
- `CNT_W`, 16, width of the frame-length configuration and word counter.

Ports:
- `axi_clk`, in, 1: the only clock; all logic is on its rising edge.
- `axi_rst`, in, 1: synchronous, active-high reset.
- `s_axis_valid`, in, 1: result word from the array wrapper is valid.
- `s_axis_data`, in, `IN_W`: result word.
- `s_axis_ready`, out, 1: block accepts a word this cycle.
- `m_axis_valid`, out, 1: output slice is valid.
- `m_axis_data`, out, `OUT_W`: output slice.
- `m_axis_last`, out, 1: final slice of the frame.
- `m_axis_ready`, in, 1: DMA accepts a slice.
- `cfg_frame_len`, in, `CNT_W`: input words per frame. 0 is treated as 1.
- `frame_done`, out, 1: single-cycle pulse on the handshake of the last slice.

## Operation
- Internal state:
  - `data_q` (`IN_W`), `full` (1), `slice_idx` (0..N-1), `word_cnt` (`CNT_W`), `len_q` (`CNT_W`).
- Input handshake:
  - Occurs when `s_axis_valid && s_axis_ready`.
  - On acceptance, load `data_q`, set `full`=1 and `slice_idx`=0.
- Output:
  - `m_axis_valid` = `full`.
  - `m_axis_data` = `data_q[slice_idx*OUT_W +: OUT_W]`. Slice 0, bits [47:0], is sent first; slice 2, bits [143:96], is sent last.
- Output handshake: occurs when `m_axis_valid && m_axis_ready`.
  - If `slice_idx` < N-1: `slice_idx`++.
  - If `slice_idx` = N-1 and no simultaneous input handshake: `full`=0.
  - If `slice_idx` = N-1 and an input handshake occurs in the same cycle: reload `data_q`, keep `full`=1, set `slice_idx`=0.
- `s_axis_ready` = `!axi_rst && (!full || (m_axis_ready && slice_idx==N-1))`.
  - This is combinational from `m_axis_ready`; the path is intentional.
- Frame counting:
  - When `word_cnt`=0 and an input word is accepted, latch `len_q` = max(`cfg_frame_len`, 1).
  - `cfg_frame_len` changes mid-frame have no effect until the next frame.
  - `word_cnt` increments on each output handshake with `slice_idx`=N-1.
  - It wraps to 0 when it reaches `len_q` on that handshake.
- `m_axis_last` = `full && slice_idx==N-1 && word_cnt==len_q-1`.
- `frame_done` registered: asserts the cycle after the handshake of a slice carrying `m_axis_last`=1, for exactly one cycle.
- Reset, `axi_rst`=1 at a clock edge:
  - `full`, `slice_idx`, `word_cnt`, `len_q`, `frame_done` go to 0; `data_q` goes to 0.
  - Outputs: `m_axis_valid`=0, `m_axis_data`=0, `m_axis_last`=0, `frame_done`=0, `s_axis_ready`=0 while reset is high.
  - Reset mid-word or mid-frame discards the partial word and the frame count. No partial `last` is emitted.

## Timing
- Latency: word accepted at edge T gives slice 0 valid in cycle T+1.
- With `m_axis_ready` held 1: slices go out at T+1, T+2, T+3.
  - The next word is accepted in cycle T+3, alongside slice 2, so slice 0 of the next word appears in T+4.
  - Sustained rate: 1 input word per N cycles, 1 output slice per cycle.
- Backpressure:
  - `m_axis_data`, `m_axis_last` and `m_axis_valid` hold stable while `m_axis_valid && !m_axis_ready`.
  - `s_axis_ready` stays 0 until slice N-1 is being taken.
- `s_axis_ready` is independent of `s_axis_valid`; `m_axis_valid` is independent of `m_axis_ready`.

## Test plan
- **Single word:** word 0x…_000300020001 pattern, `cfg_frame_len`=1, ready=1.
  - Slices in order are [47:0], [95:48], [143:96] on cycles T+1..T+3.
  - `m_axis_last`=1 only on the third slice; `frame_done` pulses at T+4.
- **Back-to-back:** 4 words with valid held high, ready=1, `cfg_frame_len`=4.
  - 12 contiguous output beats with no bubble.
  - `s_axis_ready` high every 3rd cycle; `last` only on beat 12.
- **Random backpressure:** `m_axis_ready` toggled randomly, 50%, over 100 words with `cfg_frame_len`=10.
  - Scoreboard matches all 300 slices.
  - Output is stable while stalled; 10 `last` and 10 `frame_done` pulses.
- **Length boundaries:** `cfg_frame_len`=0 gives `last` on every word. Changing `cfg_frame_len` from 2 to 3 mid-frame: the current frame still ends after 2 words, the next after 3.
- **Reset mid-operation:** assert `axi_rst` after slice 1 of word 2 in a 4-word frame.
  - Outputs go to 0 the next cycle.
  - After release, a fresh 4-word frame gives `last` on its 12th beat.
- **Simultaneous events:** input valid arrives in the same cycle slice 2 is accepted.
  - Word is taken with no lost or duplicated slice.
  - `slice_idx` returns to 0 with `full` still 1.

Source files
------------

// File: rtl/result_stream_serializer.sv
// Splits each wide result word into N narrow AXI-Stream beats, low slice first.
// Counts words per frame to drive m_axis_last and pulses frame_done after it.
module result_stream_serializer #(
    parameter int IN_W  = 144,
    parameter int OUT_W = 48,
    parameter int CNT_W = 16
) (
    input  logic             axi_clk,
    input  logic             axi_rst,
    input  logic             s_axis_valid,
    input  logic [IN_W-1:0]  s_axis_data,
    output logic             s_axis_ready,
    output logic             m_axis_valid,
    output logic [OUT_W-1:0] m_axis_data,
    output logic             m_axis_last,
    input  logic             m_axis_ready,
    input  logic [CNT_W-1:0] cfg_frame_len,
    output logic             frame_done
);
    localparam int N     = IN_W / OUT_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [IN_W-1:0]  r_data_q;
    logic             r_full;
    logic [IDX_W-1:0] r_slice_idx;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_len_q;
    logic             r_frame_done;

    logic             w_last_slice;
    logic             w_last_word;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_word_done;
    logic             w_frame_start;
    logic [CNT_W-1:0] w_len_m1;
    logic [CNT_W-1:0] w_cfg_len;
    logic [CNT_W-1:0] w_cnt_next;
    logic [OUT_W-1:0] w_slices [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_slices[i] = r_data_q[i*OUT_W +: OUT_W];
        end
    end

    // Ready looks straight through at m_axis_ready so a new word can load in
    // the same cycle the final slice leaves, keeping the output bubble-free.
    assign w_last_slice  = (r_slice_idx == LAST_IDX);
    assign s_axis_ready  = !axi_rst && (!r_full || (m_axis_ready && w_last_slice));
    assign w_in_hs       = s_axis_valid && s_axis_ready;
    assign w_out_hs      = r_full && m_axis_ready;
    assign w_word_done   = w_out_hs && w_last_slice;

    assign w_len_m1      = r_len_q - CNT_W'(1);
    assign w_last_word   = (r_word_cnt == w_len_m1);
    assign w_cfg_len     = (cfg_frame_len == '0) ? CNT_W'(1) : cfg_frame_len;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_cnt_next = r_word_cnt;
        if (w_word_done) begin
            w_cnt_next = w_last_word ? '0 : r_word_cnt + CNT_W'(1);
        end
    end

    // A word that lands on count zero (after any same-cycle wrap) opens a frame,
    // so back-to-back frames still pick up a changed length.
    assign w_frame_start = w_in_hs && (w_cnt_next == '0);

    assign m_axis_valid  = r_full;
    assign m_axis_data   = w_slices[r_slice_idx];
    assign m_axis_last   = r_full && w_last_slice && w_last_word;
    assign frame_done    = r_frame_done;

    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            // NOTE: the word buffer is a plain register, not a RAM, so it is cleared to make m_axis_data read 0 after reset.
            r_data_q    <= '0;
            r_full      <= 1'b0;
            r_slice_idx <= '0;
        end else if (w_in_hs) begin
            r_data_q    <= s_axis_data;
            r_full      <= 1'b1;
            r_slice_idx <= '0;
        end else if (w_out_hs) begin
            if (w_last_slice) begin
                r_full      <= 1'b0;
                r_slice_idx <= '0;
            end else begin
                r_slice_idx <= r_slice_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_word_cnt   <= '0;
            r_len_q      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_word_cnt   <= w_cnt_next;
            r_frame_done <= w_out_hs && m_axis_last;
            if (w_frame_start) begin
                r_len_q <= w_cfg_len;
            end
        end
    end

endmodule

// File: tb/tb_result_stream_serializer.sv
// Directed bench for result_stream_serializer: cycle-exact scenarios plus a
// streaming engine that scores every slice, last flag and frame_done pulse.
module tb_result_stream_serializer;
    localparam int IN_W  = 144;
    localparam int OUT_W = 48;
    localparam int CNT_W = 16;
    localparam int N     = 3;
    localparam int LIMIT = 5000;

    logic             axi_clk = 1'b0;
    logic             axi_rst;
    logic             s_axis_valid;
    logic [IN_W-1:0]  s_axis_data;
    logic             s_axis_ready;
    logic             m_axis_valid;
    logic [OUT_W-1:0] m_axis_data;
    logic             m_axis_last;
    logic             m_axis_ready;
    logic [CNT_W-1:0] cfg_frame_len;
    logic             frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 axi_clk = ~axi_clk;

    result_stream_serializer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .axi_clk       (axi_clk),
        .axi_rst       (axi_rst),
        .s_axis_valid  (s_axis_valid),
        .s_axis_data   (s_axis_data),
        .s_axis_ready  (s_axis_ready),
        .m_axis_valid  (m_axis_valid),
        .m_axis_data   (m_axis_data),
        .m_axis_last   (m_axis_last),
        .m_axis_ready  (m_axis_ready),
        .cfg_frame_len (cfg_frame_len),
        .frame_done    (frame_done)
    );

    // Lane j of word k holds {k[7:0], j+1}; word 0 therefore ends in ..._0003_0002_0001.
    function automatic logic [IN_W-1:0] make_word(input int k);
        logic [IN_W-1:0] w;
        logic [7:0]      kb;
        kb = 8'(k);
        for (int j = 0; j < IN_W / 16; j++) begin
            w[j*16 +: 16] = {kb, 8'(j + 1)};
        end
        return w;
    endfunction

    function automatic logic [OUT_W-1:0] slice_of(input int k, input int s);
        logic [IN_W-1:0] w;
        w = make_word(k);
        return w[s*OUT_W +: OUT_W];
    endfunction

    function automatic int eff_len(input logic [CNT_W-1:0] l);
        return (l == '0) ? 1 : int'(l);
    endfunction

    task automatic run_stream(input string name, input int n_words, input int base,
                              input logic [CNT_W-1:0] len_a, input logic [CNT_W-1:0] len_b,
                              input int ready_pct, output int n_last, output int n_done,
                              output int first_beat, output int last_beat);
        int in_sent, out_words, out_slice, pos, cur_len, cyc;
        logic exp_done, exp_valid, exp_rdy, exp_last, prev_stall, prev_last;
        logic [OUT_W-1:0] prev_data, exp_data;
        in_sent = 0; out_words = 0; out_slice = 0; pos = 0; cyc = 0;
        cur_len = eff_len(len_a);
        exp_done = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        n_last = 0; n_done = 0; first_beat = -1; last_beat = -1;
        cfg_frame_len = len_a;
        while ((out_words < n_words || exp_done) && cyc < LIMIT) begin
            @(negedge axi_clk);
            if (in_sent >= 1) cfg_frame_len = len_b;
            s_axis_valid = (in_sent < n_words);
            s_axis_data  = make_word(base + in_sent);
            m_axis_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
            #1;
            exp_valid = (in_sent > out_words);
            exp_rdy   = !exp_valid || (m_axis_ready && out_slice == N - 1);
            exp_last  = (out_slice == N - 1) && (pos == cur_len - 1);
            exp_data  = slice_of(base + out_words, out_slice);
            n_checks++;
            if (m_axis_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL %s valid cyc=%0d got=%b exp=%b", name, cyc, m_axis_valid, exp_valid);
            end
            n_checks++;
            if (s_axis_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL %s s_ready cyc=%0d got=%b exp=%b", name, cyc, s_axis_ready, exp_rdy);
            end
            n_checks++;
            if (frame_done !== exp_done) begin
                n_fail++;
                $display("FAIL %s frame_done cyc=%0d got=%b exp=%b", name, cyc, frame_done, exp_done);
            end
            if (frame_done === 1'b1) n_done++;
            if (exp_valid) begin
                n_checks++;
                if (m_axis_data !== exp_data) begin
                    n_fail++;
                    $display("FAIL %s data word=%0d slice=%0d got=%h exp=%h", name, out_words, out_slice, m_axis_data, exp_data);
                end
                n_checks++;
                if (m_axis_last !== exp_last) begin
                    n_fail++;
                    $display("FAIL %s last word=%0d slice=%0d got=%b exp=%b", name, out_words, out_slice, m_axis_last, exp_last);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if (m_axis_valid !== 1'b1 || m_axis_data !== prev_data || m_axis_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL %s stall_hold cyc=%0d got=%b/%h/%b exp=1/%h/%b", name, cyc, m_axis_valid, m_axis_data, m_axis_last, prev_data, prev_last);
                end
            end
            prev_stall = m_axis_valid && !m_axis_ready;
            prev_data  = m_axis_data;
            prev_last  = m_axis_last;
            exp_done   = 1'b0;
            if (s_axis_valid && s_axis_ready) in_sent++;
            if (m_axis_valid && m_axis_ready) begin
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
                if (m_axis_last === 1'b1) n_last++;
                exp_done = exp_last;
                if (out_slice == N - 1) begin
                    out_slice = 0;
                    out_words++;
                    if (pos == cur_len - 1) begin
                        pos = 0;
                        cur_len = eff_len(len_b);
                    end else begin
                        pos++;
                    end
                end else begin
                    out_slice++;
                end
            end
            cyc++;
        end
        if (cyc >= LIMIT) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout words_out=%0d exp=%0d", name, out_words, n_words);
        end
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
    endtask

    task automatic test_reset();
        axi_rst = 1'b1; s_axis_valid = 1'b1; s_axis_data = make_word(5);
        m_axis_ready = 1'b1; cfg_frame_len = 16'd1;
        repeat (2) @(posedge axi_clk);
        @(negedge axi_clk); #1;
        n_checks++;
        if ({m_axis_valid, m_axis_last, frame_done, s_axis_ready} !== 4'b0000 || m_axis_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b l=%b fd=%b rdy=%b d=%h exp all 0", m_axis_valid, m_axis_last, frame_done, s_axis_ready, m_axis_data);
        end
        s_axis_valid = 1'b0;
        axi_rst = 1'b0;
        #1;
        n_checks++;
        if (s_axis_ready !== 1'b1 || m_axis_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0", s_axis_ready, m_axis_valid);
        end
    endtask

    task automatic test_single_word();
        logic [OUT_W-1:0] exp_d [3];
        exp_d[0] = 48'h0003_0002_0001;
        exp_d[1] = 48'h0006_0005_0004;
        exp_d[2] = 48'h0009_0008_0007;
        @(negedge axi_clk);
        cfg_frame_len = 16'd1; m_axis_ready = 1'b1;
        s_axis_valid = 1'b1; s_axis_data = make_word(0);
        #1;
        n_checks++;
        if (s_axis_ready !== 1'b1 || m_axis_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept got rdy=%b v=%b exp rdy=1 v=0", s_axis_ready, m_axis_valid);
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge axi_clk);
            s_axis_valid = 1'b0;
            #1;
            n_checks++;
            if (m_axis_valid !== 1'b1 || m_axis_data !== exp_d[s] || m_axis_last !== (s == 2)) begin
                n_fail++;
                $display("FAIL single_slice%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", s, m_axis_valid, m_axis_data, m_axis_last, exp_d[s], (s == 2));
            end
            n_checks++;
            if (frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL single_early_done slice%0d got=%b exp=0", s, frame_done);
            end
        end
        @(negedge axi_clk); #1;
        n_checks++;
        if (frame_done !== 1'b1 || m_axis_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done got fd=%b v=%b exp fd=1 v=0", frame_done, m_axis_valid);
        end
        @(negedge axi_clk); #1;
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_pulse got=%b exp=0", frame_done);
        end
    endtask

    task automatic test_back_to_back();
        int nl, nd, fb, lb;
        run_stream("b2b", 4, 1, 16'd4, 16'd4, 100, nl, nd, fb, lb);
        n_checks++;
        if (nl !== 1 || nd !== 1 || lb - fb !== 11) begin
            n_fail++;
            $display("FAIL b2b_summary got last=%0d done=%0d span=%0d exp 1/1/11", nl, nd, lb - fb);
        end
    endtask

    task automatic test_backpressure();
        int nl, nd, fb, lb;
        run_stream("bp", 100, 16, 16'd10, 16'd10, 50, nl, nd, fb, lb);
        n_checks++;
        if (nl !== 10 || nd !== 10) begin
            n_fail++;
            $display("FAIL bp_counts got last=%0d done=%0d exp 10/10", nl, nd);
        end
    endtask

    task automatic test_length_boundaries();
        int nl, nd, fb, lb;
        run_stream("len0", 3, 130, 16'd0, 16'd0, 100, nl, nd, fb, lb);
        n_checks++;
        if (nl !== 3 || nd !== 3) begin
            n_fail++;
            $display("FAIL len0_counts got last=%0d done=%0d exp 3/3", nl, nd);
        end
        run_stream("len2to3", 5, 140, 16'd2, 16'd3, 100, nl, nd, fb, lb);
        n_checks++;
        if (nl !== 2 || nd !== 2) begin
            n_fail++;
            $display("FAIL len2to3_counts got last=%0d done=%0d exp 2/2", nl, nd);
        end
    endtask

    task automatic test_reset_mid();
        int acc, beats, cyc, nl, nd, fb, lb;
        acc = 0; beats = 0; cyc = 0;
        cfg_frame_len = 16'd4; m_axis_ready = 1'b1;
        while (beats < 5 && cyc < 50) begin
            @(negedge axi_clk);
            s_axis_valid = (acc < 4);
            s_axis_data  = make_word(200 + acc);
            #1;
            if (s_axis_valid && s_axis_ready) acc++;
            if (m_axis_valid && m_axis_ready) beats++;
            cyc++;
        end
        @(negedge axi_clk);
        axi_rst = 1'b1; s_axis_valid = 1'b1;
        #1;
        n_checks++;
        if (s_axis_ready !== 1'b0 || m_axis_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_during got rdy=%b v=%b exp rdy=0 v=1", s_axis_ready, m_axis_valid);
        end
        @(negedge axi_clk); #1;
        n_checks++;
        if ({m_axis_valid, m_axis_last, frame_done, s_axis_ready} !== 4'b0000 || m_axis_data !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got v=%b l=%b fd=%b rdy=%b d=%h exp all 0", m_axis_valid, m_axis_last, frame_done, s_axis_ready, m_axis_data);
        end
        s_axis_valid = 1'b0;
        axi_rst = 1'b0;
        run_stream("rstmid_fresh", 4, 210, 16'd4, 16'd4, 100, nl, nd, fb, lb);
        n_checks++;
        if (nl !== 1 || nd !== 1 || lb - fb !== 11) begin
            n_fail++;
            $display("FAIL rstmid_frame got last=%0d done=%0d span=%0d exp 1/1/11", nl, nd, lb - fb);
        end
    endtask

    task automatic test_simultaneous();
        logic [OUT_W-1:0] exp_d [3];
        @(negedge axi_clk);
        cfg_frame_len = 16'd1; m_axis_ready = 1'b1;
        s_axis_valid = 1'b1; s_axis_data = make_word(8'h40);
        @(negedge axi_clk);
        s_axis_valid = 1'b0;
        #1;
        n_checks++;
        if (m_axis_valid !== 1'b1 || m_axis_data !== 48'h4003_4002_4001) begin
            n_fail++;
            $display("FAIL simul_w0s0 got v=%b d=%h exp v=1 d=400340024001", m_axis_valid, m_axis_data);
        end
        @(negedge axi_clk); #1;
        n_checks++;
        if (m_axis_data !== 48'h4006_4005_4004) begin
            n_fail++;
            $display("FAIL simul_w0s1 got=%h exp=400640054004", m_axis_data);
        end
        @(negedge axi_clk);
        m_axis_ready = 1'b0;
        s_axis_valid = 1'b1; s_axis_data = make_word(8'h41);
        #1;
        n_checks++;
        if (m_axis_data !== 48'h4009_4008_4007 || m_axis_last !== 1'b1 || s_axis_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_w0s2_stalled got d=%h l=%b rdy=%b exp d=400940084007 l=1 rdy=0", m_axis_data, m_axis_last, s_axis_ready);
        end
        m_axis_ready = 1'b1;
        #1;
        n_checks++;
        if (s_axis_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_ready_path got=%b exp=1", s_axis_ready);
        end
        exp_d[0] = 48'h4103_4102_4101;
        exp_d[1] = 48'h4106_4105_4104;
        exp_d[2] = 48'h4109_4108_4107;
        for (int s = 0; s < 3; s++) begin
            @(negedge axi_clk);
            s_axis_valid = 1'b0;
            #1;
            n_checks++;
            if (m_axis_valid !== 1'b1 || m_axis_data !== exp_d[s] || m_axis_last !== (s == 2) || frame_done !== (s == 0)) begin
                n_fail++;
                $display("FAIL simul_w1s%0d got v=%b d=%h l=%b fd=%b exp v=1 d=%h l=%b fd=%b", s, m_axis_valid, m_axis_data, m_axis_last, frame_done, exp_d[s], (s == 2), (s == 0));
            end
        end
        @(negedge axi_clk); #1;
        n_checks++;
        if (m_axis_valid !== 1'b0 || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_drain got v=%b fd=%b exp v=0 fd=1", m_axis_valid, frame_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_length_boundaries();
        test_reset_mid();
        test_simultaneous();
        repeat (2) @(posedge axi_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
